btn_debounce: RTL and testbench
===============================

Name: btn_debounce

Overview:
Front-end conditioner for the stopwatch push-buttons (Start, Stop, Record). It takes raw, asynchronous, bouncing active-low button levels. Per button it produces a synchronised, debounced active-low level that drives the stopwatch's i_fStart/i_fStop/i_fRecord, plus single-cycle press and release strobes. It sits directly between the board pins and the stopwatch core.

Parameters:
NUM_BTN, 3, number of independent button channels (bit 0 = Start, 1 = Stop, 2 = Record).
STABLE_CNT, 1_000_000, cycles a new level must persist before acceptance (10 ms at 100 MHz); legal range ≥ 2.
CNT_W, $clog2(STABLE_CNT), debounce counter width (derived, not overridden).

Ports:
i_Clk  input  1  system clock, rising edge.
i_Rst  input  1  reset; synchronous, active-high.
i_Btn  input  NUM_BTN  raw button levels, active-low (0 = pressed), asynchronous to i_Clk.
o_Btn  output  NUM_BTN  debounced level, active-low; connects to the stopwatch start/stop/record inputs.
o_fPress  output  NUM_BTN  1-cycle strobe on an accepted 1→0 transition of o_Btn.
o_fRelease  output  NUM_BTN  1-cycle strobe on an accepted 0→1 transition of o_Btn.

Behaviour:
- All channels are identical and independent; no cross-channel interaction.
- Synchroniser: 2-FF chain per channel (s1 then s2). Reset value is 1 (released).
- Per-channel FSM has 4 states:
  - RELEASED (reset state): o_Btn=1. If s2=0, go to PRESS_WAIT with cnt=0.
  - PRESS_WAIT: if s2=1, go back to RELEASED with cnt=0 (bounce rejected). Else if cnt==STABLE_CNT-1, go to PRESSED. Else cnt+1.
  - PRESSED: o_Btn=0. If s2=1, go to RELEASE_WAIT with cnt=0.
  - RELEASE_WAIT: if s2=0, go back to PRESSED with cnt=0. Else if cnt==STABLE_CNT-1, go to RELEASED. Else cnt+1.
- o_Btn, o_fPress and o_fRelease are registered and decoded from the state register.
  - o_Btn=0 in PRESSED and RELEASE_WAIT; o_Btn=1 in RELEASED and PRESS_WAIT.
  - o_fPress=1 for exactly the one cycle after the PRESS_WAIT→PRESSED transition edge.
  - o_fRelease=1 for exactly the one cycle after the RELEASE_WAIT→RELEASED transition edge.
- Latency: number the edge that first samples the new raw level into s1 as edge 1. o_Btn changes and the strobe asserts after edge STABLE_CNT+3.
- Acceptance: s2 must hold the new level for STABLE_CNT+1 consecutive cycles.
  - A raw pulse of ≤ STABLE_CNT cycles produces no change on any output.
  - A raw pulse of ≥ STABLE_CNT+1 cycles is accepted.
- Counter width: cnt never exceeds STABLE_CNT-1, so no wrap is possible. cnt is cleared on every state change.
- Simultaneous presses on several channels: each channel resolves independently, and strobes may coincide.
- Reset asserted mid-operation (any state) takes effect on the next edge:
  - state = RELEASED, cnt=0, s1=s2=1, o_Btn all 1, strobes all 0.
  - A button held low through reset is re-accepted after the normal latency once reset deasserts.
- Reset output values: o_Btn={NUM_BTN{1'b1}}, o_fPress=0, o_fRelease=0.

Decomposition:
- Shared package holds:
  - the state encoding constants RELEASED=2'b00, PRESS_WAIT=2'b01, PRESSED=2'b10, RELEASE_WAIT=2'b11;
  - the default STABLE_CNT;
  - the button index constants BTN_START=0, BTN_STOP=1, BTN_RECORD=2.
- One sub-module, debounce_ch: a single channel (synchroniser, FSM, counter). btn_debounce instantiates it NUM_BTN times with a generate loop.

Test Plan:
- Bench uses STABLE_CNT=4 and NUM_BTN=3 throughout.
- Reset and idle: i_Rst=1 for 3 cycles, i_Btn=3'b111 → o_Btn=3'b111, strobes 0, and they stay so for 50 cycles after release.
- Clean press: drive i_Btn[0]=0 and hold → o_Btn[0] falls after edge 7 (counted from first sampling edge), o_fPress[0]=1 for exactly 1 cycle, other bits unchanged.
- Bounce rejection and boundary:
  - i_Btn[1] low for 4 cycles, then high → no output change.
  - Low for 5 cycles → o_Btn[1] falls with a 1-cycle o_fPress[1].
  - o_Btn[1] returns high after the release latency, with a 1-cycle o_fRelease[1].
- Bouncy release: from PRESSED, toggle i_Btn[2] 1,0,1,0 at 2-cycle intervals, then hold 1 → exactly one o_fRelease[2], asserted STABLE_CNT+3 edges after the final 0→1.
- Simultaneous: all three pressed on the same edge → o_fPress=3'b111 in a single cycle.
- Reset mid-operation: assert i_Rst while channel 0 is in PRESSED with i_Btn[0] held 0 → next cycle o_Btn[0]=1 with no o_fRelease; after deassert, o_fPress[0] re-fires after edge 7.

Source files
------------

// File: rtl/btn_debounce_pkg.sv
// Shared types and constants for the stopwatch push-button conditioner.
// State encoding, default debounce length and button channel indices.
package btn_debounce_pkg;

    typedef enum logic [1:0] {
        StReleased    = 2'b00,
        StPressWait   = 2'b01,
        StPressed     = 2'b10,
        StReleaseWait = 2'b11
    } btn_state_e;

    // 10 ms at 100 MHz.
    localparam int unsigned StableCntDefault = 1_000_000;
    localparam int unsigned NumBtnDefault    = 3;

    localparam int unsigned BtnStart  = 0;
    localparam int unsigned BtnStop   = 1;
    localparam int unsigned BtnRecord = 2;

endpackage

// File: rtl/debounce_ch.sv
// One button channel: 2-FF synchroniser, four-state debounce FSM and stability counter.
// Levels are active-low; strobes are single-cycle and registered.
module debounce_ch
    import btn_debounce_pkg::*;
#(
    parameter int unsigned STABLE_CNT = StableCntDefault
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic btn_i,
    output logic btn_o,
    output logic press_o,
    output logic release_o
);

    localparam int unsigned     CNT_W  = $clog2(STABLE_CNT);
    localparam logic [CNT_W-1:0] CntMax = CNT_W'(STABLE_CNT - 1);

    logic             s1_q;
    logic             s2_q;
    btn_state_e       state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             btn_q;
    logic             press_q;
    logic             release_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            s1_q <= 1'b1;
            s2_q <= 1'b1;
        end else begin
            s1_q <= btn_i;
            s2_q <= s1_q;
        end
    end

    // Counter is cleared on every state change, so it never exceeds CntMax.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= StReleased;
            cnt_q     <= '0;
            btn_q     <= 1'b1;
            press_q   <= 1'b0;
            release_q <= 1'b0;
        end else begin
            press_q   <= 1'b0;
            release_q <= 1'b0;
            unique case (state_q)
                StReleased: begin
                    if (!s2_q) begin
                        state_q <= StPressWait;
                        cnt_q   <= '0;
                    end
                end
                StPressWait: begin
                    if (s2_q) begin
                        state_q <= StReleased;
                        cnt_q   <= '0;
                    end else if (cnt_q == CntMax) begin
                        state_q <= StPressed;
                        cnt_q   <= '0;
                        btn_q   <= 1'b0;
                        press_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                StPressed: begin
                    if (s2_q) begin
                        state_q <= StReleaseWait;
                        cnt_q   <= '0;
                    end
                end
                StReleaseWait: begin
                    if (!s2_q) begin
                        state_q <= StPressed;
                        cnt_q   <= '0;
                    end else if (cnt_q == CntMax) begin
                        state_q   <= StReleased;
                        cnt_q     <= '0;
                        btn_q     <= 1'b1;
                        release_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= StReleased;
                    cnt_q   <= '0;
                    btn_q   <= 1'b1;
                end
            endcase
        end
    end

    assign btn_o     = btn_q;
    assign press_o   = press_q;
    assign release_o = release_q;

endmodule

// File: rtl/btn_debounce.sv
// Debounced, synchronised front end for the stopwatch Start/Stop/Record buttons.
// Channels are independent copies of debounce_ch.
module btn_debounce
    import btn_debounce_pkg::*;
#(
    parameter int unsigned NUM_BTN    = NumBtnDefault,
    parameter int unsigned STABLE_CNT = StableCntDefault
) (
    input  logic               i_Clk,
    input  logic               i_Rst,
    input  logic [NUM_BTN-1:0] i_Btn,
    output logic [NUM_BTN-1:0] o_Btn,
    output logic [NUM_BTN-1:0] o_fPress,
    output logic [NUM_BTN-1:0] o_fRelease
);

    for (genvar g = 0; g < NUM_BTN; g++) begin : g_ch
        debounce_ch #(
            .STABLE_CNT(STABLE_CNT)
        ) u_ch (
            .clk_i    (i_Clk),
            .rst_i    (i_Rst),
            .btn_i    (i_Btn[g]),
            .btn_o    (o_Btn[g]),
            .press_o  (o_fPress[g]),
            .release_o(o_fRelease[g])
        );
    end

endmodule

// File: tb/tb_btn_debounce.sv
// Randomised and directed bench for btn_debounce against a run-length reference model.
// The model accepts a level once the twice-delayed raw input has differed for STABLE_CNT+1 edges.
module tb_btn_debounce;

    localparam int unsigned NB = 3;
    localparam int unsigned SC = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [NB-1:0] btn = '1;
    logic [NB-1:0] o_btn;
    logic [NB-1:0] o_press;
    logic [NB-1:0] o_rel;

    always #5 clk = ~clk;

    btn_debounce #(
        .NUM_BTN   (NB),
        .STABLE_CNT(SC)
    ) dut (
        .i_Clk     (clk),
        .i_Rst     (rst),
        .i_Btn     (btn),
        .o_Btn     (o_btn),
        .o_fPress  (o_press),
        .o_fRelease(o_rel)
    );

    int unsigned n_vec = 0;
    int unsigned n_bad = 0;
    int unsigned edge_n = 0;
    int unsigned press_cnt[NB];
    int unsigned rel_cnt[NB];
    int unsigned last_press[NB];
    int unsigned last_rel[NB];
    int unsigned all_press_seen;

    // Reference model: raw input delayed two edges, accepted level, run length of disagreement.
    logic [NB-1:0] m_d1 = '1;
    logic [NB-1:0] m_d2 = '1;
    logic [NB-1:0] m_lvl = '1;
    int unsigned   m_run[NB];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, got, exp, edge_n);
        end
    endtask

    task automatic clr();
        for (int c = 0; c < NB; c++) begin
            press_cnt[c]  = 0;
            rel_cnt[c]    = 0;
            last_press[c] = 0;
            last_rel[c]   = 0;
        end
        all_press_seen = 0;
    endtask

    task automatic tick();
        logic [NB-1:0] exp_p;
        logic [NB-1:0] exp_r;
        exp_p = '0;
        exp_r = '0;
        if (rst) begin
            m_d1  = '1;
            m_d2  = '1;
            m_lvl = '1;
            for (int c = 0; c < NB; c++) m_run[c] = 0;
        end else begin
            for (int c = 0; c < NB; c++) begin
                if (m_d2[c] != m_lvl[c]) begin
                    m_run[c]++;
                    if (m_run[c] == SC + 1) begin
                        m_lvl[c] = m_d2[c];
                        m_run[c] = 0;
                        if (m_lvl[c]) exp_r[c] = 1'b1;
                        else          exp_p[c] = 1'b1;
                    end
                end else begin
                    m_run[c] = 0;
                end
            end
            m_d2 = m_d1;
            m_d1 = btn;
        end
        @(posedge clk);
        #1;
        edge_n++;
        check("o_Btn", 32'(o_btn), 32'(m_lvl));
        check("o_fPress", 32'(o_press), 32'(exp_p));
        check("o_fRelease", 32'(o_rel), 32'(exp_r));
        for (int c = 0; c < NB; c++) begin
            if (o_press[c]) begin
                press_cnt[c]++;
                last_press[c] = edge_n;
            end
            if (o_rel[c]) begin
                rel_cnt[c]++;
                last_rel[c] = edge_n;
            end
        end
        if (o_press == '1) all_press_seen++;
    endtask

    initial begin
        int unsigned t0;
        for (int c = 0; c < NB; c++) m_run[c] = 0;
        clr();

        // Reset and idle
        rst = 1'b1;
        btn = '1;
        repeat (3) tick();
        rst = 1'b0;
        repeat (50) tick();
        check("idle_strobes", press_cnt[0] + press_cnt[1] + press_cnt[2]
              + rel_cnt[0] + rel_cnt[1] + rel_cnt[2], 0);
        check("idle_level", 32'(o_btn), 32'h7);

        // Clean press on Start
        clr();
        btn[0] = 1'b0;
        t0 = edge_n + 1;
        repeat (10) tick();
        check("press0_latency", last_press[0] - t0 + 1, SC + 3);
        check("press0_count", press_cnt[0], 1);
        check("press0_others", press_cnt[1] + press_cnt[2], 0);

        // Stop: 4-cycle pulse is rejected
        clr();
        btn[1] = 1'b0;
        repeat (SC) tick();
        btn[1] = 1'b1;
        repeat (12) tick();
        check("short_pulse_press", press_cnt[1], 0);
        check("short_pulse_level", 32'(o_btn[1]), 1);

        // Stop: 5-cycle pulse is accepted and later released
        clr();
        btn[1] = 1'b0;
        repeat (SC + 1) tick();
        btn[1] = 1'b1;
        t0 = edge_n + 1;
        repeat (12) tick();
        check("min_pulse_press", press_cnt[1], 1);
        check("min_pulse_release", rel_cnt[1], 1);
        check("min_pulse_rel_latency", last_rel[1] - t0 + 1, SC + 3);

        // Record: press, then bouncy release
        btn[2] = 1'b0;
        repeat (10) tick();
        clr();
        btn[2] = 1'b1; repeat (2) tick();
        btn[2] = 1'b0; repeat (2) tick();
        btn[2] = 1'b1; repeat (2) tick();
        btn[2] = 1'b0; repeat (2) tick();
        btn[2] = 1'b1;
        t0 = edge_n + 1;
        repeat (12) tick();
        check("bouncy_rel_count", rel_cnt[2], 1);
        check("bouncy_rel_latency", last_rel[2] - t0 + 1, SC + 3);
        check("bouncy_no_press", press_cnt[2], 0);

        // Simultaneous press on all channels
        btn = '1;
        repeat (12) tick();
        clr();
        btn = '0;
        repeat (10) tick();
        check("simul_press", all_press_seen, 1);

        // Reset while Start is held pressed
        clr();
        rst = 1'b1;
        tick();
        check("rst_mid_level", 32'(o_btn), 32'h7);
        check("rst_mid_no_release", rel_cnt[0] + rel_cnt[1] + rel_cnt[2], 0);
        rst = 1'b0;
        t0 = edge_n + 1;
        repeat (10) tick();
        check("rst_mid_repress", last_press[0] - t0 + 1, SC + 3);

        // Random bouncing with occasional resets; every edge checked against the model
        for (int k = 0; k < 2000; k++) begin
            int unsigned pct;
            pct = ((k / 100) % 2 == 0) ? 30 : 8;
            for (int c = 0; c < NB; c++) begin
                if ($urandom_range(0, 99) < pct) btn[c] = ~btn[c];
            end
            rst = ($urandom_range(0, 199) == 0);
            tick();
        end
        rst = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
